// File: rtl/rx_pkg.sv
// Shared types and constants for the receive-side sync monitor.
//   state_t   : link state (LOSS, ACQ, SYNC)
//   K28_5     : comma byte value
//   ERR_LVL_W : width of the error-level hysteresis counter
//   is_comma  : true when a decoded symbol is a K28.5 comma
package rx_pkg;

    typedef enum logic [1:0] {
        LOSS = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } state_t;

    localparam logic [7:0] K28_5     = 8'hBC;
    localparam int         ERR_LVL_W = 3;

    function automatic logic is_comma(input logic [7:0] d, input logic k);
        return k && (d == K28_5);
    endfunction

endpackage

// File: rtl/rx_sync_fsm_if.sv
// Symbol bus between the decoder control stage, the sync monitor and the
// receive datapath.
//   data/kout/code_err           : decoded symbol, one per clock
//   data_out/kout_out/data_valid : forwarded symbol, 1-cycle latency
// Handshake: there is no backpressure. A symbol is presented every clock;
// the forwarded symbol is meaningful only in a cycle where data_valid=1,
// and the consumer must take it in that cycle.
interface rx_sync_fsm_if;
    logic [7:0] data;
    logic       kout;
    logic       code_err;
    logic [7:0] data_out;
    logic       kout_out;
    logic       data_valid;

    modport master (
        output data, kout, code_err,
        input  data_out, kout_out, data_valid
    );

    modport slave (
        input  data, kout, code_err,
        output data_out, kout_out, data_valid
    );
endinterface

// File: rtl/rx_sync_fsm_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count up by one (holds at all-ones)
//   clr        : synchronous clear, wins over inc
//   count      : current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/rx_sync_fsm.sv
// Comma-based link synchronisation monitor with error-level hysteresis.
//   clk, reset_n : symbol clock, asynchronous active-low reset
//   bus          : symbol in / forwarded symbol out (rx_sync_fsm_if.slave)
//   err_clr      : synchronous clear of err_count
//   sync_ok      : link synchronised (state is SYNC)
//   err_level    : current error level while in SYNC
//   lost_sync    : one-cycle pulse on SYNC->LOSS
//   err_count    : saturating count of code_err cycles
//   state_dbg    : current FSM state, for observation
module rx_sync_fsm
    import rx_pkg::*;
#(
    parameter int ACQ_COMMAS      = 3,
    parameter int GOOD_TO_RECOVER = 4,
    parameter int MAX_ERR         = 4,
    parameter int ERRCNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rx_sync_fsm_if.slave         bus,
    input  logic                 err_clr,
    output logic                 sync_ok,
    output logic [ERR_LVL_W-1:0] err_level,
    output logic                 lost_sync,
    output logic [ERRCNT_W-1:0]  err_count,
    output state_t               state_dbg
);

    state_t                 state, state_nx;
    logic [3:0]             comma_cnt, comma_nx;
    logic [3:0]             good_cnt, good_nx;
    logic [ERR_LVL_W-1:0]   level_nx;
    logic                   lost_nx;
    logic                   comma;
    logic [ERR_LVL_W-1:0]   level_inc;
    logic [3:0]             comma_inc;
    logic [3:0]             good_inc;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= LOSS;
            comma_cnt      <= '0;
            good_cnt       <= '0;
            err_level      <= '0;
            lost_sync      <= 1'b0;
            sync_ok        <= 1'b0;
            bus.data_out   <= 8'h00;
            bus.kout_out   <= 1'b0;
            bus.data_valid <= 1'b0;
        end else begin
            state          <= state_nx;
            comma_cnt      <= comma_nx;
            good_cnt       <= good_nx;
            err_level      <= level_nx;
            lost_sync      <= lost_nx;
            sync_ok        <= (state_nx == SYNC);
            bus.data_out   <= bus.data;
            bus.kout_out   <= bus.kout;
            // Qualified on the state the symbol was accepted in, so the
            // error that drops sync is never marked valid.
            bus.data_valid <= (state == SYNC) && !bus.code_err;
        end
    end

    always_comb begin
        state_nx  = state;
        comma_nx  = comma_cnt;
        good_nx   = good_cnt;
        level_nx  = err_level;
        lost_nx   = 1'b0;
        // A comma carrying a decode error is an error, not a comma.
        comma     = is_comma(bus.data, bus.kout) && !bus.code_err;
        level_inc = err_level + ERR_LVL_W'(1);
        comma_inc = comma_cnt + 4'd1;
        good_inc  = good_cnt + 4'd1;

        case (state)
            LOSS: begin
                if (comma) begin
                    if (ACQ_COMMAS == 1) begin
                        state_nx = SYNC;
                        comma_nx = '0;
                        level_nx = '0;
                        good_nx  = '0;
                    end else begin
                        state_nx = ACQ;
                        comma_nx = 4'd1;
                    end
                end
            end
            ACQ: begin
                if (bus.code_err) begin
                    state_nx = LOSS;
                    comma_nx = '0;
                end else if (comma) begin
                    if (comma_inc == 4'(ACQ_COMMAS)) begin
                        state_nx = SYNC;
                        comma_nx = '0;
                        level_nx = '0;
                        good_nx  = '0;
                    end else begin
                        comma_nx = comma_inc;
                    end
                end
            end
            SYNC: begin
                if (bus.code_err) begin
                    good_nx = '0;
                    if (level_inc == ERR_LVL_W'(MAX_ERR)) begin
                        state_nx = LOSS;
                        level_nx = '0;
                        lost_nx  = 1'b1;
                        comma_nx = '0;
                    end else begin
                        level_nx = level_inc;
                    end
                end else if (err_level != '0) begin
                    // Each run of good symbols earns back one level.
                    if (good_inc == 4'(GOOD_TO_RECOVER)) begin
                        level_nx = err_level - ERR_LVL_W'(1);
                        good_nx  = '0;
                    end else begin
                        good_nx = good_inc;
                    end
                end else begin
                    good_nx = '0;
                end
            end
            default: begin
                state_nx = LOSS;
                comma_nx = '0;
                good_nx  = '0;
                level_nx = '0;
            end
        endcase
    end

    sat_counter #(.W(ERRCNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .inc   (bus.code_err),
        .clr   (err_clr),
        .count (err_count)
    );

endmodule

// File: tb/tb_rx_sync_fsm.sv
// Bench for rx_sync_fsm: directed symbol sequences, a behavioural model of
// the link rules checked every cycle, and literal checkpoints.
module tb_rx_sync_fsm;
    import rx_pkg::*;

    localparam int ACQ     = 3;
    localparam int GOOD    = 4;
    localparam int MAXE    = 4;
    localparam int CW      = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            err_clr = 1'b0;
    logic            sync_ok;
    logic [2:0]      err_level;
    logic            lost_sync;
    logic [CW-1:0]   err_count;
    state_t          state_dbg;

    int tests  = 0;
    int errors = 0;

    rx_sync_fsm_if bus ();

    rx_sync_fsm #(
        .ACQ_COMMAS      (ACQ),
        .GOOD_TO_RECOVER (GOOD),
        .MAX_ERR         (MAXE),
        .ERRCNT_W        (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .err_clr   (err_clr),
        .sync_ok   (sync_ok),
        .err_level (err_level),
        .lost_sync (lost_sync),
        .err_count (err_count),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = no sync, 1 = gathering commas, 2 = synchronised
    int         m_phase, m_commas, m_level, m_good, m_cnt;
    logic [7:0] m_data;
    bit         m_k, m_valid, m_lost, m_sync;

    always @(posedge clk or negedge reset_n) begin
        bit is_k285;
        bit good_in_sync;
        if (!reset_n) begin
            m_phase = 0; m_commas = 0; m_level = 0; m_good = 0; m_cnt = 0;
            m_data = 8'h00; m_k = 0; m_valid = 0; m_lost = 0; m_sync = 0;
        end else begin
            is_k285      = bus.kout && (bus.data == 8'hBC);
            good_in_sync = 0;
            m_data  = bus.data;
            m_k     = bus.kout;
            m_valid = (m_phase == 2) && !bus.code_err;
            m_lost  = 0;

            if (err_clr)                           m_cnt = 0;
            else if (bus.code_err && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;

            if (bus.code_err) begin
                if (m_phase == 1) begin
                    m_phase = 0;
                    m_commas = 0;
                end else if (m_phase == 2) begin
                    m_good  = 0;
                    m_level = m_level + 1;
                    if (m_level == MAXE) begin
                        m_phase = 0; m_level = 0; m_lost = 1; m_commas = 0;
                    end
                end
            end else if (m_phase == 2) begin
                good_in_sync = 1;
            end else if (is_k285) begin
                m_commas = m_commas + 1;
                if (m_commas >= ACQ) begin
                    m_phase = 2; m_commas = 0; m_level = 0; m_good = 0;
                end else begin
                    m_phase = 1;
                end
            end

            if (good_in_sync) begin
                if (m_level == 0) begin
                    m_good = 0;
                end else begin
                    m_good = m_good + 1;
                    if (m_good == GOOD) begin
                        m_level = m_level - 1;
                        m_good  = 0;
                    end
                end
            end
            m_sync = (m_phase == 2);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("sync_ok",    sync_ok,        m_sync);
            chk("data_out",   bus.data_out,   m_data);
            chk("kout_out",   bus.kout_out,   m_k);
            chk("data_valid", bus.data_valid, m_valid);
            chk("err_level",  err_level,      m_level);
            chk("lost_sync",  lost_sync,      m_lost);
            chk("err_count",  err_count,      m_cnt);
        end
    end

    // ---------------- drivers ----------------
    // Drive one symbol; returns just after the edge that consumed it.
    task automatic send(input logic [7:0] d, input logic k, input logic e, input logic c);
        @(negedge clk);
        bus.data     = d;
        bus.kout     = k;
        bus.code_err = e;
        err_clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic comma();
        send(8'hBC, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic good(input logic [7:0] d);
        send(d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic err();
        send(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        bus.data     = 8'h00;
        bus.kout     = 1'b0;
        bus.code_err = 1'b0;
        err_clr      = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.data     = 8'h00;
        bus.kout     = 1'b0;
        bus.code_err = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst sync_ok",    sync_ok, 0);
        chk("rst data_valid", bus.data_valid, 0);
        chk("rst err_count",  err_count, 0);
        chk("rst err_level",  err_level, 0);
        reset_n = 1'b1;

        // acquisition with three commas
        comma(); chk("acq1 sync_ok", sync_ok, 0);
        comma(); chk("acq2 sync_ok", sync_ok, 0);
        comma();
        chk("acq3 sync_ok", sync_ok, 1);
        chk("acq3 err_level", err_level, 0);
        chk("acq3 data_valid", bus.data_valid, 0);
        good(8'h55);
        chk("first valid", bus.data_valid, 1);
        chk("first data_out", bus.data_out, 8'h55);

        // error during acquisition drops back to loss
        do_reset();
        comma(); comma(); err();
        chk("acqerr sync_ok", sync_ok, 0);
        chk("acqerr err_count", err_count, 1);
        comma(); comma();
        chk("reacq2 sync_ok", sync_ok, 0);
        comma();
        chk("reacq3 sync_ok", sync_ok, 1);

        // hysteresis: 1 err, 4 good, 1 err, 3 good
        err();
        chk("hys e1 level", err_level, 1);
        chk("hys e1 valid", bus.data_valid, 0);
        good(8'h11); good(8'h22); good(8'h33);
        chk("hys g3 level", err_level, 1);
        good(8'h44);
        chk("hys g4 level", err_level, 0);
        chk("hys g4 valid", bus.data_valid, 1);
        err();
        chk("hys e2 level", err_level, 1);
        good(8'h66); good(8'h77); good(8'h88);
        chk("hys end level", err_level, 1);
        chk("hys end sync", sync_ok, 1);

        // clear the counter while still in sync (4th good restores level 0)
        send(8'h99, 1'b0, 1'b0, 1'b1);
        chk("clr err_count", err_count, 0);
        chk("clr level", err_level, 0);

        // four errors in a row lose sync
        err(); err(); err();
        chk("loss e3 sync", sync_ok, 1);
        chk("loss e3 level", err_level, 3);
        chk("loss e3 lost", lost_sync, 0);
        err();
        chk("loss e4 lost", lost_sync, 1);
        chk("loss e4 sync", sync_ok, 0);
        chk("loss e4 level", err_level, 0);
        chk("loss e4 count", err_count, 4);
        good(8'h01);
        chk("loss pulse end", lost_sync, 0);

        // saturation of the error counter
        for (int i = 0; i < 65535; i++) err();
        chk("sat count", err_count, 16'hFFFF);
        err();
        chk("sat hold", err_count, 16'hFFFF);
        send(8'h00, 1'b0, 1'b1, 1'b1);
        chk("clr wins", err_count, 0);

        // comma with decode error is an error, not a comma
        send(8'hBC, 1'b1, 1'b1, 1'b0);
        chk("badcomma sync", sync_ok, 0);
        chk("badcomma count", err_count, 1);
        comma(); comma();
        chk("badcomma acq2", sync_ok, 0);
        comma();
        chk("badcomma acq3", sync_ok, 1);

        // asynchronous reset mid-sync
        err();
        good(8'hA5);
        chk("pre-rst level", err_level, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst sync_ok",    sync_ok, 0);
        chk("arst data_out",   bus.data_out, 0);
        chk("arst kout_out",   bus.kout_out, 0);
        chk("arst data_valid", bus.data_valid, 0);
        chk("arst err_level",  err_level, 0);
        chk("arst lost_sync",  lost_sync, 0);
        chk("arst err_count",  err_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        good(8'h3C);
        chk("post-rst sync", sync_ok, 0);
        chk("post-rst lost", lost_sync, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
